// File: rtl/pulse_scheduler_pkg.sv
// Shared definitions for the pulse scheduler: FSM state encoding and
// default parameter values.
package pulse_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_LEN_W = 3;
    localparam int DEF_GAP   = 2;

endpackage

// File: rtl/pulse_scheduler_shreg.sv
// Loadable shift register: a one-cycle load of len produces a run of len+1
// ones on pulse, starting the cycle after the load.
module pulse_shreg #(
    parameter int LEN_W = 3,
    parameter int DEPTH = 1 << LEN_W
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load,
    input  logic [LEN_W-1:0] len,
    output logic             pulse
);

    logic [DEPTH-1:0] sh;
    logic [DEPTH-1:0] mask;

    // len+1 low-order ones; DEPTH covers the largest len without overflow
    always_comb begin
        mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mask[i] = (LEN_W'(i) <= len);
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            sh <= '0;
        end else if (load) begin
            sh <= mask;
        end else begin
            sh <= sh >> 1;
        end
    end

    assign pulse = sh[0];

endmodule

// File: rtl/pulse_scheduler.sv
// Round-robin pulse scheduler: grants one requester at a time, emits a pulse
// of len+1 cycles followed by GAP mandatory low cycles.
module pulse_scheduler
    import pulse_sched_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int LEN_W = DEF_LEN_W,
    parameter int GAP   = DEF_GAP
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*LEN_W-1:0] req_len,
    output logic [NREQ-1:0]       gnt,
    output logic                  pulse,
    output logic                  busy,
    output logic                  done,
    output state_t                dbg_state
);

    // Handshake: req is a level held by the requester; gnt is a one-cycle
    // strobe marking the first pulse cycle. Requests are only sampled in IDLE.

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

    state_t           state, state_n;
    logic [PTR_W-1:0] last, last_n;
    logic [PTR_W-1:0] win, cand;
    logic             found;
    logic [LEN_W-1:0] win_len;
    logic [LEN_W-1:0] len_q, len_n;
    logic [LEN_W-1:0] cnt, cnt_n;
    logic [3:0]       gcnt, gcnt_n;
    logic [NREQ-1:0]  gnt_n;
    logic             busy_n, done_n, load;

    // Search starts just after the last granted index and wraps
    always_comb begin
        win   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = PTR_W'((int'(last) + k) % NREQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        win_len = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (PTR_W'(i) == win) begin
                win_len = req_len[i*LEN_W +: LEN_W];
            end
        end
    end

    always_comb begin
        state_n = state;
        last_n  = last;
        len_n   = len_q;
        cnt_n   = cnt;
        gcnt_n  = gcnt;
        gnt_n   = '0;
        load    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (found) begin
                    state_n = ST_PULSE;
                    last_n  = win;
                    len_n   = win_len;
                    cnt_n   = '0;
                    load    = 1'b1;
                    for (int i = 0; i < NREQ; i++) begin
                        gnt_n[i] = (PTR_W'(i) == win);
                    end
                end
            end
            ST_PULSE: begin
                if (cnt == len_q) begin
                    state_n = ST_GAP;
                    gcnt_n  = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_GAP: begin
                if (gcnt == GAP_LAST) begin
                    state_n = ST_IDLE;
                end else begin
                    gcnt_n = gcnt + 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        // Outputs are registered from the next-state view so they line up
        // with the state they describe.
        busy_n = (state_n != ST_IDLE);
        done_n = (state_n == ST_GAP) && (gcnt_n == GAP_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            last  <= PTR_W'(NREQ - 1);
            len_q <= '0;
            cnt   <= '0;
            gcnt  <= '0;
            gnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            last  <= last_n;
            len_q <= len_n;
            cnt   <= cnt_n;
            gcnt  <= gcnt_n;
            gnt   <= gnt_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

    pulse_shreg #(
        .LEN_W (LEN_W)
    ) u_shreg (
        .clk   (clk),
        .clear (rst),
        .load  (load),
        .len   (len_n),
        .pulse (pulse)
    );

    assign dbg_state = state;

endmodule
